echo_adc_capture: RTL and testbench
===================================

Name: echo_adc_capture

Overview:
Receive-side partner of the excitation/AD sequencer.
- Consumes the per-cycle sync pulse and the periodic AD start strobes.
- Runs one serial ADC read per strobe (CS_n/SCLK/SDO, MSB first) and emits each sample with its index inside the current 10 ms cycle.
- Latches the first threshold-crossing echo per cycle, giving the time-of-flight index to downstream processing.

Parameters:
ADC_BITS, 12, sample width and number of SCLK periods per read
SCLK_DIV, 1, clk_50M cycles per SCLK half-period (1 gives 25 MHz SCLK)
IDX_W, 12, width of sample index counters
HOLDOFF, 2, number of initial samples per cycle excluded from echo detection (blanking)

Ports:
clk_50M  input  1  system clock, 50 MHz
rst_n  input  1  reset, asynchronous, active-low
sys_start_pulse  input  1  one-cycle T0 marker; starts a new measurement cycle
AD_start  input  1  one-cycle strobe; request one ADC conversion/read
threshold  input  ADC_BITS  echo detection level, unsigned, sampled when used
adc_sdo  input  1  ADC serial data out
adc_cs_n  output  1  ADC chip select, active-low
adc_sclk  output  1  ADC serial clock, idles low
busy  output  1  read transaction in progress
sample_valid  output  1  one-cycle strobe; sample_data/sample_idx valid
sample_data  output  ADC_BITS  last captured sample, held between strobes
sample_idx  output  IDX_W  index of sample_data within current cycle
echo_found  output  1  sticky per cycle: first echo detected
echo_idx  output  IDX_W  sample index of first echo
overrun  output  1  sticky per cycle: AD_start arrived while busy

Behaviour:
- Reset (rst_n low, async): adc_cs_n=1, adc_sclk=0, busy=0, sample_valid=0, sample_data=0, sample_idx=0, echo_found=0, echo_idx=0, overrun=0, FSM=IDLE, internal index=0.
- All outputs are registered.
- FSM states: IDLE, SHIFT.
- IDLE → SHIFT on an edge with AD_start=1 and sys_start_pulse=0.
  - Same edge: adc_cs_n<=0, adc_sclk<=0, busy<=1, bit and phase counters cleared.
- SHIFT, per bit:
  - adc_sclk low for SCLK_DIV cycles, then high for SCLK_DIV cycles.
  - On the edge that drives adc_sclk 0→1, adc_sdo is shifted into the LSB of the shift register (MSB arrives first).
- SHIFT → IDLE on the edge ending the ADC_BITS-th high phase, i.e. exactly 2*ADC_BITS*SCLK_DIV cycles after the accepting edge (24 at defaults). Same edge:
  - adc_cs_n<=1, adc_sclk<=0, busy<=0.
  - sample_valid<=1 for one cycle; sample_data<=full shifted word.
  - sample_idx<=internal index; internal index then increments.
- AD_start while FSM=SHIFT, including on the completion edge: ignored, overrun<=1.
- Internal index saturates at all-ones. Later samples still emit, with sample_idx=all-ones.
- Echo detection, evaluated on each sample_valid edge:
  - Condition: echo_found=0, internal index ≥ HOLDOFF, and shifted word ≥ threshold (unsigned).
  - Result: echo_found<=1, echo_idx<=internal index.
  - Later crossings in the same cycle are ignored.
- sys_start_pulse=1, in any state, takes priority over everything. On that edge:
  - Any transaction in flight is aborted: adc_cs_n<=1, adc_sclk<=0, busy<=0, FSM<=IDLE, no sample_valid.
  - Internal index<=0, echo_found<=0, echo_idx<=0, overrun<=0.
  - sample_data and sample_idx hold their values.
  - An AD_start on the same edge is dropped and does not set overrun.
- Minimum AD_start spacing is 2*ADC_BITS*SCLK_DIV+1 cycles (25 at defaults). The 34-cycle strobe period therefore never overruns.

Test Plan:
- Defaults, threshold=0x800. sys_start_pulse, then AD_start, adc_sdo driving 0xA5C MSB first → adc_cs_n low 24 cycles, 12 SCLK rising edges, sample_valid 24 cycles after the strobe edge, sample_data=0xA5C, sample_idx=0, echo_found=0 (blanked by HOLDOFF).
- Five strobes at 34-cycle spacing, data 0x100, 0x900, 0x200, 0x950, 0xFFF → sample_idx 0..4; echo_found=1 after the 4th sample, echo_idx=3; the 5th sample leaves echo_idx=3.
- Second AD_start 10 cycles after the first → no extra transaction, overrun=1, single sample_valid.
- sys_start_pulse 8 cycles into a read → adc_cs_n=1 and adc_sclk=0 next cycle; no sample_valid; next read reports sample_idx=0; overrun and echo_found cleared.
- sys_start_pulse and AD_start on the same cycle → no transaction, overrun stays 0.
- rst_n asserted mid-SHIFT → all outputs at reset values immediately (async); a fresh sys_start_pulse and AD_start after release read correctly.

Source files
------------

// File: rtl/echo_adc_capture.sv
// Receive-side ADC capture: one serial read per AD_start strobe, per-cycle
// sample indexing and first-echo (time-of-flight) latching.
module echo_adc_capture #(
   parameter int ADC_BITS = 12,
   parameter int SCLK_DIV = 1,
   parameter int IDX_W    = 12,
   parameter int HOLDOFF  = 2
) (
   input  logic                clk_50M,
   input  logic                rst_n,
   input  logic                sys_start_pulse,
   input  logic                AD_start,
   input  logic [ADC_BITS-1:0] threshold,
   input  logic                adc_sdo,
   output logic                adc_cs_n,
   output logic                adc_sclk,
   output logic                busy,
   output logic                sample_valid,
   output logic [ADC_BITS-1:0] sample_data,
   output logic [IDX_W-1:0]    sample_idx,
   output logic                echo_found,
   output logic [IDX_W-1:0]    echo_idx,
   output logic                overrun
);

   localparam int PH_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam int BIT_W = (ADC_BITS > 1) ? $clog2(ADC_BITS) : 1;
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SCLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(ADC_BITS - 1);
   localparam logic [IDX_W-1:0] IDX_MAX  = '1;
   localparam logic [IDX_W-1:0] HOLD_IDX = IDX_W'(HOLDOFF);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t              state, state_nxt;
   logic [PH_W-1:0]     phase, phase_nxt;
   logic [BIT_W-1:0]    bit_cnt, bit_cnt_nxt;
   logic [ADC_BITS-1:0] shreg, shreg_nxt;
   logic [IDX_W-1:0]    idx, idx_nxt;
   logic                cs_n_nxt, sclk_nxt, busy_nxt, valid_nxt;
   logic [ADC_BITS-1:0] data_nxt;
   logic [IDX_W-1:0]    sample_idx_nxt, echo_idx_nxt;
   logic                echo_found_nxt, overrun_nxt;

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         phase        <= '0;
         bit_cnt      <= '0;
         shreg        <= '0;
         idx          <= '0;
         adc_cs_n     <= 1'b1;
         adc_sclk     <= 1'b0;
         busy         <= 1'b0;
         sample_valid <= 1'b0;
         sample_data  <= '0;
         sample_idx   <= '0;
         echo_found   <= 1'b0;
         echo_idx     <= '0;
         overrun      <= 1'b0;
      end else begin
         state        <= state_nxt;
         phase        <= phase_nxt;
         bit_cnt      <= bit_cnt_nxt;
         shreg        <= shreg_nxt;
         idx          <= idx_nxt;
         adc_cs_n     <= cs_n_nxt;
         adc_sclk     <= sclk_nxt;
         busy         <= busy_nxt;
         sample_valid <= valid_nxt;
         sample_data  <= data_nxt;
         sample_idx   <= sample_idx_nxt;
         echo_found   <= echo_found_nxt;
         echo_idx     <= echo_idx_nxt;
         overrun      <= overrun_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      phase_nxt      = phase;
      bit_cnt_nxt    = bit_cnt;
      shreg_nxt      = shreg;
      idx_nxt        = idx;
      cs_n_nxt       = adc_cs_n;
      sclk_nxt       = adc_sclk;
      busy_nxt       = busy;
      valid_nxt      = 1'b0;
      data_nxt       = sample_data;
      sample_idx_nxt = sample_idx;
      echo_found_nxt = echo_found;
      echo_idx_nxt   = echo_idx;
      overrun_nxt    = overrun;

      // The cycle marker wins over everything, including a coincident strobe.
      if (sys_start_pulse) begin
         state_nxt      = IDLE;
         cs_n_nxt       = 1'b1;
         sclk_nxt       = 1'b0;
         busy_nxt       = 1'b0;
         idx_nxt        = '0;
         echo_found_nxt = 1'b0;
         echo_idx_nxt   = '0;
         overrun_nxt    = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (AD_start) begin
                  state_nxt   = SHIFT;
                  cs_n_nxt    = 1'b0;
                  sclk_nxt    = 1'b0;
                  busy_nxt    = 1'b1;
                  phase_nxt   = '0;
                  bit_cnt_nxt = '0;
                  shreg_nxt   = '0;
               end
            end
            SHIFT: begin
               if (AD_start) overrun_nxt = 1'b1;
               if (phase == PH_LAST) begin
                  phase_nxt = '0;
                  sclk_nxt  = !adc_sclk;
                  if (!adc_sclk) begin
                     shreg_nxt = {shreg[ADC_BITS-2:0], adc_sdo};
                  end else if (bit_cnt == BIT_LAST) begin
                     // End of the last high phase: word is complete.
                     state_nxt      = IDLE;
                     cs_n_nxt       = 1'b1;
                     sclk_nxt       = 1'b0;
                     busy_nxt       = 1'b0;
                     valid_nxt      = 1'b1;
                     data_nxt       = shreg;
                     sample_idx_nxt = idx;
                     if (idx != IDX_MAX) idx_nxt = idx + 1'b1;
                     if (!echo_found && idx >= HOLD_IDX && shreg >= threshold) begin
                        echo_found_nxt = 1'b1;
                        echo_idx_nxt   = idx;
                     end
                  end else begin
                     bit_cnt_nxt = bit_cnt + 1'b1;
                  end
               end else begin
                  phase_nxt = phase + 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_echo_adc_capture.sv
// Directed self-checking bench for echo_adc_capture with a behavioural
// serial ADC that presents the next bit after each SCLK falling edge.
module tb_echo_adc_capture;

   logic        clk_50M = 1'b0;
   logic        rst_n;
   logic        sys_start_pulse;
   logic        AD_start;
   logic [11:0] threshold;
   logic        adc_sdo;
   logic        adc_cs_n, adc_sclk, busy, sample_valid;
   logic [11:0] sample_data, sample_idx, echo_idx;
   logic        echo_found, overrun;

   int checks = 0;
   int failures = 0;

   logic [11:0] adc_word = 12'h000;
   int          bit_ptr = 0;

   int          rd_valid_cnt, rd_valid_at, rd_cs_low, rd_sclk_rise;
   logic [11:0] rd_data, rd_idx;
   logic        rd_busy0, rd_cs_after_sync, rd_sclk_after_sync;

   echo_adc_capture dut (
      .clk_50M(clk_50M), .rst_n(rst_n), .sys_start_pulse(sys_start_pulse),
      .AD_start(AD_start), .threshold(threshold), .adc_sdo(adc_sdo),
      .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .busy(busy),
      .sample_valid(sample_valid), .sample_data(sample_data),
      .sample_idx(sample_idx), .echo_found(echo_found), .echo_idx(echo_idx),
      .overrun(overrun)
   );

   always #10 clk_50M = ~clk_50M;

   // ADC model: MSB out when selected, next bit after every SCLK fall.
   always @(negedge adc_cs_n) begin
      bit_ptr = 11;
      adc_sdo = adc_word[bit_ptr];
   end
   always @(negedge adc_sclk) begin
      if (!adc_cs_n && bit_ptr > 0) begin
         bit_ptr = bit_ptr - 1;
         adc_sdo = adc_word[bit_ptr];
      end
   end

   task automatic pulse_sync();
      sys_start_pulse = 1'b1;
      @(negedge clk_50M);
      sys_start_pulse = 1'b0;
   endtask

   // Strobe a read, then observe window+1 negedge sample points (point n
   // shows the state after the n-th edge following the accepting edge).
   task automatic run_read(input logic [11:0] word, input int window,
                           input int extra_ad_at, input int sync_at);
      logic prev;
      adc_word = word;
      AD_start = 1'b1;
      @(negedge clk_50M);
      AD_start = 1'b0;
      rd_valid_cnt = 0; rd_valid_at = -1; rd_cs_low = 0; rd_sclk_rise = 0;
      rd_busy0 = busy; prev = 1'b0;
      for (int n = 0; n <= window; n++) begin
         if (!adc_cs_n) rd_cs_low++;
         if (adc_sclk && !prev) rd_sclk_rise++;
         prev = adc_sclk;
         if (sample_valid) begin
            rd_valid_cnt++; rd_valid_at = n; rd_data = sample_data; rd_idx = sample_idx;
         end
         if (sync_at >= 0 && n == sync_at + 1) begin
            rd_cs_after_sync = adc_cs_n; rd_sclk_after_sync = adc_sclk;
         end
         if (n < window) begin
            AD_start = (n == extra_ad_at);
            sys_start_pulse = (n == sync_at);
            @(negedge clk_50M);
            AD_start = 1'b0;
            sys_start_pulse = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; sys_start_pulse = 1'b0; AD_start = 1'b0;
      threshold = 12'h800; adc_sdo = 1'b0;
      repeat (3) @(negedge clk_50M);
      checks++; if (adc_cs_n !== 1'b1) begin failures++; $display("[TB] FAIL reset_cs_n got %b want 1", adc_cs_n); end
      checks++; if (adc_sclk !== 1'b0) begin failures++; $display("[TB] FAIL reset_sclk got %b want 0", adc_sclk); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
      checks++; if (sample_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got %b want 0", sample_valid); end
      checks++; if (sample_data !== 12'h000) begin failures++; $display("[TB] FAIL reset_data got %h want 000", sample_data); end
      checks++; if ({echo_found, overrun, echo_idx, sample_idx} !== 26'd0) begin failures++; $display("[TB] FAIL reset_flags got %b%b %h %h want zeros", echo_found, overrun, echo_idx, sample_idx); end
      rst_n = 1'b1;
      @(negedge clk_50M);
   endtask

   task automatic test_single_read();
      pulse_sync();
      run_read(12'hA5C, 30, -1, -1);
      checks++; if (rd_busy0 !== 1'b1) begin failures++; $display("[TB] FAIL single_busy got %b want 1", rd_busy0); end
      checks++; if (rd_cs_low != 24) begin failures++; $display("[TB] FAIL single_cs_low got %0d want 24", rd_cs_low); end
      checks++; if (rd_sclk_rise != 12) begin failures++; $display("[TB] FAIL single_sclk_rises got %0d want 12", rd_sclk_rise); end
      checks++; if (rd_valid_cnt != 1 || rd_valid_at != 24) begin failures++; $display("[TB] FAIL single_valid got cnt=%0d at=%0d want cnt=1 at=24", rd_valid_cnt, rd_valid_at); end
      checks++; if (rd_data !== 12'hA5C) begin failures++; $display("[TB] FAIL single_data got %h want a5c", rd_data); end
      checks++; if (rd_idx !== 12'd0) begin failures++; $display("[TB] FAIL single_idx got %0d want 0", rd_idx); end
      checks++; if (echo_found !== 1'b0) begin failures++; $display("[TB] FAIL single_echo_blanked got %b want 0", echo_found); end
      checks++; if (adc_cs_n !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL single_idle got cs_n=%b busy=%b want 1 0", adc_cs_n, busy); end
   endtask

   task automatic test_five_strobes();
      logic [11:0] words [5];
      logic        exp_found [5];
      words = '{12'h100, 12'h900, 12'h200, 12'h950, 12'hFFF};
      exp_found = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      pulse_sync();
      for (int i = 0; i < 5; i++) begin
         run_read(words[i], 33, -1, -1);
         checks++; if (rd_valid_cnt != 1 || rd_data !== words[i] || rd_idx !== 12'(i)) begin failures++; $display("[TB] FAIL five_sample%0d got cnt=%0d data=%h idx=%0d want 1 %h %0d", i, rd_valid_cnt, rd_data, rd_idx, words[i], i); end
         checks++; if (echo_found !== exp_found[i]) begin failures++; $display("[TB] FAIL five_echo_found%0d got %b want %b", i, echo_found, exp_found[i]); end
      end
      checks++; if (echo_idx !== 12'd3) begin failures++; $display("[TB] FAIL five_echo_idx got %0d want 3", echo_idx); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL five_no_overrun got %b want 0", overrun); end
   endtask

   task automatic test_overrun();
      run_read(12'h123, 33, 9, -1);
      checks++; if (rd_valid_cnt != 1 || rd_cs_low != 24) begin failures++; $display("[TB] FAIL overrun_single_txn got valid=%0d cs_low=%0d want 1 24", rd_valid_cnt, rd_cs_low); end
      checks++; if (rd_data !== 12'h123 || rd_idx !== 12'd5) begin failures++; $display("[TB] FAIL overrun_sample got %h idx %0d want 123 idx 5", rd_data, rd_idx); end
      checks++; if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL overrun_flag got %b want 1", overrun); end
   endtask

   task automatic test_sync_abort();
      run_read(12'h777, 30, -1, 7);
      checks++; if (rd_cs_after_sync !== 1'b1 || rd_sclk_after_sync !== 1'b0) begin failures++; $display("[TB] FAIL abort_pins got cs_n=%b sclk=%b want 1 0", rd_cs_after_sync, rd_sclk_after_sync); end
      checks++; if (rd_valid_cnt != 0) begin failures++; $display("[TB] FAIL abort_no_valid got %0d want 0", rd_valid_cnt); end
      checks++; if (overrun !== 1'b0 || echo_found !== 1'b0 || echo_idx !== 12'd0) begin failures++; $display("[TB] FAIL abort_clear got ovr=%b found=%b idx=%0d want 0 0 0", overrun, echo_found, echo_idx); end
      checks++; if (sample_data !== 12'h123 || sample_idx !== 12'd5) begin failures++; $display("[TB] FAIL abort_hold got %h idx %0d want 123 idx 5", sample_data, sample_idx); end
      run_read(12'h456, 30, -1, -1);
      checks++; if (rd_valid_cnt != 1 || rd_data !== 12'h456 || rd_idx !== 12'd0) begin failures++; $display("[TB] FAIL abort_next got cnt=%0d %h idx %0d want 1 456 idx 0", rd_valid_cnt, rd_data, rd_idx); end
   endtask

   task automatic test_back_to_back();
      pulse_sync();
      run_read(12'h3C3, 24, -1, -1);
      checks++; if (rd_valid_at != 24 || rd_data !== 12'h3C3 || rd_idx !== 12'd0) begin failures++; $display("[TB] FAIL b2b_first got at=%0d %h idx %0d want 24 3c3 idx 0", rd_valid_at, rd_data, rd_idx); end
      run_read(12'hC3C, 24, -1, -1);
      checks++; if (rd_valid_at != 24 || rd_data !== 12'hC3C || rd_idx !== 12'd1) begin failures++; $display("[TB] FAIL b2b_second got at=%0d %h idx %0d want 24 c3c idx 1", rd_valid_at, rd_data, rd_idx); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL b2b_no_overrun got %b want 0", overrun); end
      run_read(12'h0F0, 30, 23, -1);
      checks++; if (overrun !== 1'b1 || rd_valid_cnt != 1 || rd_cs_low != 24) begin failures++; $display("[TB] FAIL b2b_completion_strobe got ovr=%b valid=%0d cs_low=%0d want 1 1 24", overrun, rd_valid_cnt, rd_cs_low); end
      checks++; if (rd_data !== 12'h0F0 || rd_idx !== 12'd2) begin failures++; $display("[TB] FAIL b2b_third got %h idx %0d want 0f0 idx 2", rd_data, rd_idx); end
   endtask

   task automatic test_sync_with_ad();
      int cs_low;
      int valids;
      pulse_sync();
      sys_start_pulse = 1'b1; AD_start = 1'b1;
      @(negedge clk_50M);
      sys_start_pulse = 1'b0; AD_start = 1'b0;
      cs_low = 0; valids = 0;
      for (int n = 0; n < 30; n++) begin
         if (!adc_cs_n || busy) cs_low++;
         if (sample_valid) valids++;
         @(negedge clk_50M);
      end
      checks++; if (cs_low != 0 || valids != 0) begin failures++; $display("[TB] FAIL syncad_idle_no_txn got active=%0d valid=%0d want 0 0", cs_low, valids); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL syncad_idle_overrun got %b want 0", overrun); end
      run_read(12'h888, 30, 5, 5);
      checks++; if (overrun !== 1'b0 || rd_valid_cnt != 0) begin failures++; $display("[TB] FAIL syncad_busy got ovr=%b valid=%0d want 0 0", overrun, rd_valid_cnt); end
   endtask

   task automatic test_async_reset();
      pulse_sync();
      adc_word = 12'h999;
      AD_start = 1'b1;
      @(negedge clk_50M);
      AD_start = 1'b0;
      repeat (5) @(negedge clk_50M);
      checks++; if (adc_sclk !== 1'b1 || adc_cs_n !== 1'b0) begin failures++; $display("[TB] FAIL areset_pre got sclk=%b cs_n=%b want 1 0", adc_sclk, adc_cs_n); end
      #5 rst_n = 1'b0;
      #1;
      checks++; if (adc_cs_n !== 1'b1 || adc_sclk !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL areset_pins got cs_n=%b sclk=%b busy=%b want 1 0 0", adc_cs_n, adc_sclk, busy); end
      checks++; if (sample_data !== 12'h000 || sample_idx !== 12'd0 || sample_valid !== 1'b0) begin failures++; $display("[TB] FAIL areset_sample got %h idx %0d v=%b want 000 0 0", sample_data, sample_idx, sample_valid); end
      checks++; if (echo_found !== 1'b0 || echo_idx !== 12'd0 || overrun !== 1'b0) begin failures++; $display("[TB] FAIL areset_flags got %b %0d %b want 0 0 0", echo_found, echo_idx, overrun); end
      @(negedge clk_50M);
      rst_n = 1'b1;
      @(negedge clk_50M);
      pulse_sync();
      run_read(12'h5A5, 30, -1, -1);
      checks++; if (rd_valid_cnt != 1 || rd_data !== 12'h5A5 || rd_idx !== 12'd0) begin failures++; $display("[TB] FAIL areset_after got cnt=%0d %h idx %0d want 1 5a5 idx 0", rd_valid_cnt, rd_data, rd_idx); end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_five_strobes();
      test_overrun();
      test_sync_abort();
      test_back_to_back();
      test_sync_with_ad();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
